// File: rtl/pwm_meas_pkg.sv
// Shared types and default constants for the PWM period meter.
package pwm_meas_pkg;

    localparam int MEAS_CNT_W       = 24;
    localparam int MEAS_TIMEOUT_CYC = 10_000_000;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } meas_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus delay flop, producing single-cycle rise/fall strobes.
module sync_edge_det #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_dly;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_dly  <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_dly;
    assign o_fall = ~r_sync & r_dly;

endmodule

// File: rtl/pwm_period_meter.sv
// Measures high time and rising-to-rising period of a slow async signal in clk cycles,
// with a loss-of-signal watchdog.
module pwm_period_meter
    import pwm_meas_pkg::*;
#(
    parameter int CNT_W       = MEAS_CNT_W,
    parameter int TIMEOUT_CYC = MEAS_TIMEOUT_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic w_rise;
    logic w_fall;

    meas_state_t      r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [CNT_W-1:0] r_hi_lat, w_hi_lat_nx;
    logic [CNT_W-1:0] r_high, w_high_nx;
    logic [CNT_W-1:0] r_per, w_per_nx;
    logic             r_valid, w_valid_nx;
    logic             r_to, w_to_nx;

    // Reset value 1 keeps a signal already high at reset from looking like a rise.
    sync_edge_det #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (sig_in),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_hi_lat <= '0;
            r_high   <= '0;
            r_per    <= '0;
            r_valid  <= 1'b0;
            r_to     <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_hi_lat <= w_hi_lat_nx;
            r_high   <= w_high_nx;
            r_per    <= w_per_nx;
            r_valid  <= w_valid_nx;
            r_to     <= w_to_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_hi_lat_nx = r_hi_lat;
        w_high_nx   = r_high;
        w_per_nx    = r_per;
        w_valid_nx  = 1'b0;
        w_to_nx     = r_to;
        unique case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_cnt_nx   = CNT_ONE;
                    w_state_nx = HIGH;
                end
            end
            HIGH: begin
                w_cnt_nx = r_cnt + CNT_ONE;
                if (w_fall) begin
                    w_hi_lat_nx = r_cnt;
                    w_state_nx  = LOW;
                end else if (r_cnt == TO_VAL) begin
                    w_to_nx    = 1'b1;
                    w_cnt_nx   = '0;
                    w_state_nx = IDLE;
                end
            end
            LOW: begin
                w_cnt_nx = r_cnt + CNT_ONE;
                // An edge landing on the timeout cycle still counts as a measurement.
                if (w_rise) begin
                    w_per_nx   = r_cnt;
                    w_high_nx  = r_hi_lat;
                    w_valid_nx = 1'b1;
                    w_to_nx    = 1'b0;
                    w_cnt_nx   = CNT_ONE;
                    w_state_nx = HIGH;
                end else if (r_cnt == TO_VAL) begin
                    w_to_nx    = 1'b1;
                    w_cnt_nx   = '0;
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign high_cnt   = r_high;
    assign period_cnt = r_per;
    assign meas_valid = r_valid;
    assign timeout    = r_to;

endmodule

// File: tb/tb_pwm_period_meter.sv
// Randomized and directed bench for pwm_period_meter against an event-timestamp model.
module tb_pwm_period_meter;

    localparam int CW = 24;
    localparam int TO = 1000;

    logic          clk;
    logic          rst;
    logic          sig_in;
    logic [CW-1:0] high_cnt;
    logic [CW-1:0] period_cnt;
    logic          meas_valid;
    logic          timeout;

    pwm_period_meter #(
        .CNT_W       (CW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .meas_valid (meas_valid),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // raw[j] is driven after negedge j and first sampled by clock edge j+1.
    bit raw[$];
    int rs = 0;

    // Model state: timestamps (edge indices) of detected events.
    bit      armed = 1'b0;
    int      t_rise = 0;
    int      hi_held = 0;
    bit      e_v = 1'b0;
    bit      e_to = 1'b0;
    int      e_hi = 0;
    int      e_per = 0;

    function automatic bit rv(input int j);
        if (j < rs || j < 0) return 1'b1;
        return raw[j];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s @%0d obs=%0d exp=%0d", tag, raw.size(), obs, exp);
        end
    endtask

    // Synchronized level seen by the FSM at edge k is the raw value from 3 edges earlier.
    task automatic model(input int k, input bit r);
        bit s, sd;
        if (r) begin
            armed = 1'b0; e_v = 1'b0; e_to = 1'b0;
            e_hi = 0; e_per = 0; hi_held = 0; rs = k;
        end else begin
            s  = rv(k - 3);
            sd = rv(k - 4);
            e_v = 1'b0;
            if (!armed) begin
                if (s && !sd) begin
                    armed = 1'b1;
                    t_rise = k;
                end
            end else if (s && !sd) begin
                e_per = k - t_rise;
                e_hi  = hi_held;
                e_v   = 1'b1;
                e_to  = 1'b0;
                t_rise = k;
            end else if (!s && sd) begin
                hi_held = k - t_rise;
            end else if (k - t_rise == TO) begin
                e_to  = 1'b1;
                armed = 1'b0;
            end
        end
    endtask

    task automatic tick(input bit v, input bit r);
        int k;
        sig_in = v;
        rst    = r;
        raw.push_back(v);
        k = raw.size();
        @(posedge clk);
        model(k, r);
        @(negedge clk);
        chk("valid",  32'(meas_valid), 32'(e_v));
        chk("timeout", 32'(timeout),   32'(e_to));
        chk("high",   32'(high_cnt),   e_hi);
        chk("period", 32'(period_cnt), e_per);
    endtask

    task automatic hold(input bit v, input int n);
        for (int i = 0; i < n; i++) tick(v, 1'b0);
    endtask

    task automatic wave(input int h, input int p, input int n);
        for (int i = 0; i < n; i++) begin
            hold(1'b1, h);
            hold(1'b0, p - h);
        end
    endtask

    initial begin
        int h, p;
        rst    = 1'b1;
        sig_in = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);

        hold(1'b1, 2000);
        chk("idle_hi", 32'(high_cnt), 0);
        chk("idle_to", 32'(timeout), 0);

        wave(30, 100, 5);
        chk("sq_hi",  32'(high_cnt), 30);
        chk("sq_per", 32'(period_cnt), 100);

        wave(1, 2, 20);
        chk("min_hi",  32'(high_cnt), 1);
        chk("min_per", 32'(period_cnt), 2);

        wave(30, 100, 3);
        hold(1'b0, 1300);
        chk("lost_to",  32'(timeout), 1);
        chk("lost_hi",  32'(high_cnt), 30);
        chk("lost_per", 32'(period_cnt), 100);

        wave(50, 200, 4);
        chk("rest_hi",  32'(high_cnt), 50);
        chk("rest_per", 32'(period_cnt), 200);
        chk("rest_to",  32'(timeout), 0);

        wave(30, 100, 3);
        hold(1'b1, 30);
        hold(1'b0, 20);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("rst_hi", 32'(high_cnt), 0);
        wave(40, 90, 4);
        chk("post_hi",  32'(high_cnt), 40);
        chk("post_per", 32'(period_cnt), 90);

        wave(300, TO, 3);
        chk("edge_per", 32'(period_cnt), TO);
        chk("edge_to",  32'(timeout), 0);

        for (int i = 0; i < 40; i++) begin
            h = $urandom_range(1, 60);
            p = h + $urandom_range(1, 80);
            wave(h, p, 1);
        end
        hold(1'b0, 1100);
        chk("end_to", 32'(timeout), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
